// File: rtl/alu_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the shared ALU.
// Handshake: reqN is a level held until gntN; acceptance is the IDLE clock edge that sees reqN and selects it, gntN follows for one cycle, doneN pulses once when resultN/flags are valid.
interface alu_arbiter_if #(parameter int DW = 16);
  logic          req0;
  logic          req1;
  logic [4:0]    fun_sel0;
  logic [4:0]    fun_sel1;
  logic [DW-1:0] a0;
  logic [DW-1:0] b0;
  logic [DW-1:0] a1;
  logic [DW-1:0] b1;
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic [DW-1:0] result;
  logic [3:0]    flags;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [4:0]    alu_fun_sel;
  logic          alu_wf;
  logic [DW-1:0] alu_out;
  logic [3:0]    alu_flags;
  logic          busy;
  logic [7:0]    cnt0;
  logic [7:0]    cnt1;

  modport slave (
    input  req0, req1, fun_sel0, fun_sel1, a0, b0, a1, b1, alu_out, alu_flags,
    output gnt0, gnt1, done0, done1, result, flags, alu_a, alu_b, alu_fun_sel,
           alu_wf, busy, cnt0, cnt1
  );

  modport master (
    output req0, req1, fun_sel0, fun_sel1, a0, b0, a1, b1, alu_out, alu_flags,
    input  gnt0, gnt1, done0, done1, result, flags, alu_a, alu_b, alu_fun_sel,
           alu_wf, busy, cnt0, cnt1
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter sharing one ALU; fixed 4-cycle
// IDLE/ISSUE/SETTLE/DONE sequence per operation.
module alu_arbiter #(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  alu_arbiter_if.slave    bus,
  output logic [1:0]      o_dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    r_state;
  logic          r_owner;
  logic          r_last;
  logic [4:0]    r_op_fun;
  logic [DW-1:0] r_op_a;
  logic [DW-1:0] r_op_b;
  logic [DW-1:0] r_result;
  logic [3:0]    r_flags;
  logic [7:0]    r_cnt0;
  logic [7:0]    r_cnt1;

  logic w_any;
  logic w_win;

  assign w_any = bus.req0 | bus.req1;
  // On a tie the requester not served last wins; a lone request always wins.
  assign w_win = (bus.req0 & bus.req1) ? ~r_last : bus.req1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_op_fun <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_flags  <= '0;
      r_cnt0   <= '0;
      r_cnt1   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state  <= S_ISSUE;
            r_owner  <= w_win;
            r_last   <= w_win;
            r_op_fun <= w_win ? bus.fun_sel1 : bus.fun_sel0;
            r_op_a   <= w_win ? bus.a1 : bus.a0;
            r_op_b   <= w_win ? bus.b1 : bus.b0;
          end
        end
        S_ISSUE: r_state <= S_SETTLE;
        S_SETTLE: begin
          r_state  <= S_DONE;
          r_result <= bus.alu_out;
          r_flags  <= bus.alu_flags;
        end
        default: begin
          r_state <= S_IDLE;
          if (!r_owner && r_cnt0 != 8'hFF) r_cnt0 <= r_cnt0 + 8'd1;
          if (r_owner && r_cnt1 != 8'hFF)  r_cnt1 <= r_cnt1 + 8'd1;
        end
      endcase
    end
  end

  // Operand registers only change on acceptance, so they also give the hold behaviour outside ISSUE/SETTLE.
  assign bus.alu_a       = r_op_a;
  assign bus.alu_b       = r_op_b;
  assign bus.alu_fun_sel = r_op_fun;
  assign bus.alu_wf      = (r_state == S_ISSUE);

  assign bus.gnt0   = (r_state == S_ISSUE) & ~r_owner;
  assign bus.gnt1   = (r_state == S_ISSUE) &  r_owner;
  assign bus.done0  = (r_state == S_DONE)  & ~r_owner;
  assign bus.done1  = (r_state == S_DONE)  &  r_owner;
  assign bus.busy   = (r_state != S_IDLE);
  assign bus.result = r_result;
  assign bus.flags  = r_flags;
  assign bus.cnt0   = r_cnt0;
  assign bus.cnt1   = r_cnt1;

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural shared ALU, directed requests, and a
// scoreboard that checks every Done against an expected queue.
module tb_alu_arbiter;
  localparam int DW = 16;
  localparam int W  = 1 + DW + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  alu_arbiter_if #(.DW(DW)) bus ();

  alu_arbiter #(.DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: x0100 add, x0110 subtract (C = no borrow), else pass A.
  // Flags {Z,C,N,O} are registered when alu_wf is high; never reset here.
  logic [DW-1:0] alu_res;
  logic [3:0]    alu_next_flags;
  logic [3:0]    alu_flag_reg = 4'b0000;
  logic [DW:0]   alu_wide;
  logic          alu_c;
  logic          alu_o;

  always_comb begin
    alu_wide = '0;
    alu_c    = 1'b0;
    alu_o    = 1'b0;
    alu_res  = bus.alu_a;
    case (bus.alu_fun_sel[3:0])
      4'b0100: begin
        alu_wide = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
        alu_res  = alu_wide[DW-1:0];
        alu_c    = alu_wide[DW];
        alu_o    = (bus.alu_a[DW-1] == bus.alu_b[DW-1]) && (alu_res[DW-1] != bus.alu_a[DW-1]);
      end
      4'b0110: begin
        alu_res = bus.alu_a - bus.alu_b;
        alu_c   = (bus.alu_a >= bus.alu_b);
        alu_o   = (bus.alu_a[DW-1] != bus.alu_b[DW-1]) && (alu_res[DW-1] != bus.alu_a[DW-1]);
      end
      default: ;
    endcase
    alu_next_flags = {(alu_res == '0), alu_c, alu_res[DW-1], alu_o};
  end

  always @(posedge clk) if (bus.alu_wf) alu_flag_reg <= alu_next_flags;

  assign bus.alu_out   = alu_res;
  assign bus.alu_flags = alu_flag_reg;

  // Bookkeeping
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int gnt0_cyc = 0;
  int gnt1_cyc = 0;
  int gnt_overlap  = 0;
  int done_overlap = 0;
  int gnt_log[$];
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic owner, input logic [DW-1:0] res, input logic [3:0] flg);
    exp_q.push_back({owner, res, flg});
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (bus.gnt0 && bus.gnt1)   gnt_overlap++;
    if (bus.done0 && bus.done1) done_overlap++;
    if (bus.gnt0) begin gnt_log.push_back(0); gnt0_cyc = cyc; end
    if (bus.gnt1) begin gnt_log.push_back(1); gnt1_cyc = cyc; end
    if (bus.done0 || bus.done1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {30'b0, bus.done1, bus.done0}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_owner",  {31'b0, bus.done1}, {31'b0, e[W-1]});
        chk("sb_result", {16'b0, bus.result}, {16'b0, e[DW+3:4]});
        chk("sb_flags",  {28'b0, bus.flags}, {28'b0, e[3:0]});
      end
    end
  end

  // Waits at falling edges until the selected pulse is seen (0 gnt0, 1 gnt1, 2 done0, 3 done1).
  task automatic wait_sig(input int sel, input int budget);
    int   n   = 0;
    logic hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      case (sel)
        0:       hit = bus.gnt0;
        1:       hit = bus.gnt1;
        2:       hit = bus.done0;
        default: hit = bus.done1;
      endcase
    end
    if (!hit) chk($sformatf("timeout_sel%0d", sel), {31'b0, hit}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   {30'b0, bus.gnt1, bus.gnt0}, 32'd0);
    chk({tag, "_done"},  {30'b0, bus.done1, bus.done0}, 32'd0);
    chk({tag, "_busy"},  {31'b0, bus.busy}, 32'd0);
    chk({tag, "_wf"},    {31'b0, bus.alu_wf}, 32'd0);
    chk({tag, "_result"}, {16'b0, bus.result}, 32'd0);
    chk({tag, "_flags"}, {28'b0, bus.flags}, 32'd0);
    chk({tag, "_alu_a"}, {16'b0, bus.alu_a}, 32'd0);
    chk({tag, "_alu_b"}, {16'b0, bus.alu_b}, 32'd0);
    chk({tag, "_alu_fs"}, {27'b0, bus.alu_fun_sel}, 32'd0);
    chk({tag, "_cnt"},   {16'b0, bus.cnt1, bus.cnt0}, 32'd0);
    chk({tag, "_state"}, {30'b0, dbg_state}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.fun_sel0 = '0; bus.fun_sel1 = '0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Single request: 0x7FFF + 1 -> 0x8000, N=1 O=1
    @(negedge clk);
    bus.fun_sel0 = 5'b10100; bus.a0 = 16'h7FFF; bus.b0 = 16'h0001; bus.req0 = 1'b1;
    push_exp(1'b0, 16'h8000, 4'b0011);
    @(negedge clk);
    chk("t1_gnt0",  {31'b0, bus.gnt0}, 32'd1);
    chk("t1_busy",  {31'b0, bus.busy}, 32'd1);
    chk("t1_wf",    {31'b0, bus.alu_wf}, 32'd1);
    chk("t1_alu_a", {16'b0, bus.alu_a}, 32'h7FFF);
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("t1_settle_pulses", {29'b0, bus.alu_wf, bus.gnt0, bus.done0}, 32'd0);
    @(negedge clk);
    chk("t1_done0", {31'b0, bus.done0}, 32'd1);
    @(negedge clk);
    chk("t1_cnt0", {24'b0, bus.cnt0}, 32'd1);
    chk("t1_idle", {31'b0, bus.busy}, 32'd0);

    // Simultaneous requests after reset: 0 first, 1 four cycles later
    do_reset();
    gnt_log.delete();
    bus.fun_sel0 = 5'b10100; bus.a0 = 16'h0001; bus.b0 = 16'h0002;
    bus.fun_sel1 = 5'b10110; bus.a1 = 16'h0005; bus.b1 = 16'h0007;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    push_exp(1'b0, 16'h0003, 4'b0000);
    push_exp(1'b1, 16'hFFFE, 4'b0010);
    fork
      begin wait_sig(0, 10); bus.req0 = 1'b0; end
      begin wait_sig(1, 20); bus.req1 = 1'b0; end
    join
    wait_sig(3, 10);
    chk("t2_gnt_spacing", gnt1_cyc - gnt0_cyc, 32'd4);
    chk("t2_log_size", gnt_log.size(), 32'd2);
    if (gnt_log.size() == 2) begin
      chk("t2_order0", gnt_log[0], 32'd0);
      chk("t2_order1", gnt_log[1], 32'd1);
    end
    @(negedge clk);

    // Req1 held, Req0 re-raised after each Done: grants 0,1,0,1
    gnt_log.delete();
    bus.fun_sel0 = 5'b10100; bus.a0 = 16'h0010; bus.b0 = 16'h0020;
    bus.fun_sel1 = 5'b10110; bus.a1 = 16'h0003; bus.b1 = 16'h0001;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    push_exp(1'b0, 16'h0030, 4'b0000);
    push_exp(1'b1, 16'h0002, 4'b0100);
    push_exp(1'b0, 16'h0030, 4'b0000);
    push_exp(1'b1, 16'h0002, 4'b0100);
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          wait_sig(0, 30);
          bus.req0 = 1'b0;
          wait_sig(2, 10);
          if (k == 0) bus.req0 = 1'b1;
        end
      end
      begin
        for (int k = 0; k < 2; k++) wait_sig(1, 40);
        bus.req1 = 1'b0;
      end
    join
    wait_sig(3, 10);
    chk("t3_log_size", gnt_log.size(), 32'd4);
    if (gnt_log.size() == 4) begin
      chk("t3_order0", gnt_log[0], 32'd0);
      chk("t3_order1", gnt_log[1], 32'd1);
      chk("t3_order2", gnt_log[2], 32'd0);
      chk("t3_order3", gnt_log[3], 32'd1);
    end
    @(negedge clk);

    // Operand change after acceptance must not affect the operation
    bus.fun_sel0 = 5'b10110; bus.a0 = 16'h1234; bus.b0 = 16'h1234; bus.req0 = 1'b1;
    push_exp(1'b0, 16'h0000, 4'b1100);
    wait_sig(0, 10);
    bus.a0 = 16'hFFFF; bus.req0 = 1'b0;
    @(negedge clk);
    chk("t4_alu_a_held", {16'b0, bus.alu_a}, 32'h1234);
    wait_sig(2, 5);
    @(negedge clk);

    // Reset during SETTLE: no Done, outputs cleared at once, then normal service
    bus.fun_sel0 = 5'b10100; bus.a0 = 16'h0101; bus.b0 = 16'h0101; bus.req0 = 1'b1;
    wait_sig(0, 10);
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("t5_in_settle", {30'b0, dbg_state}, 32'd2);
    rst = 1'b1;
    #1;
    chk_all_zero("t5_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.fun_sel1 = 5'b10100; bus.a1 = 16'h0100; bus.b1 = 16'h0200; bus.req1 = 1'b1;
    push_exp(1'b1, 16'h0300, 4'b0000);
    wait_sig(1, 10);
    bus.req1 = 1'b0;
    wait_sig(3, 5);
    @(negedge clk);
    chk("t5_cnt1", {24'b0, bus.cnt1}, 32'd1);
    chk("t5_cnt0", {24'b0, bus.cnt0}, 32'd0);

    // 300 back-to-back Req0 operations: Cnt0 saturates at 255
    do_reset();
    bus.fun_sel0 = 5'b10100; bus.a0 = 16'h0001; bus.b0 = 16'h0001; bus.req0 = 1'b1;
    for (int i = 0; i < 300; i++) push_exp(1'b0, 16'h0002, 4'b0000);
    for (int i = 0; i < 300; i++) begin
      wait_sig(0, 10);
      if (i == 255) chk("t6_cnt0_at_255", {24'b0, bus.cnt0}, 32'd255);
    end
    bus.req0 = 1'b0;
    wait_sig(2, 5);
    @(negedge clk);
    chk("t6_cnt0_sat", {24'b0, bus.cnt0}, 32'd255);
    chk("t6_cnt1", {24'b0, bus.cnt1}, 32'd0);

    repeat (4) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("gnt_overlap", gnt_overlap, 32'd0);
    chk("done_overlap", done_overlap, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
